// File: rtl/img_ctrl_pkg.sv
// Shared types and constants for the image pipeline mode controller.
package img_ctrl_pkg;

  localparam int   COORD_W   = 11;
  localparam logic MODE_VERT = 1'b0;
  localparam logic MODE_HORZ = 1'b1;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    FLUSH    = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser followed by a stability counter; a new level is accepted
// only after DEBOUNCE_CYC consecutive differing samples. Reusable for any board switch.
module sw_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iSW,
  output logic oSTABLE
);

  localparam int CW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync_1;
  logic          sw_sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sync_1  <= 1'b0;
      sw_sync <= 1'b0;
      cnt     <= '0;
      oSTABLE <= 1'b0;
    end else begin
      sync_1  <= iSW;
      sw_sync <= sync_1;
      if (sw_sync == oSTABLE) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        oSTABLE <= sw_sync;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/image_proc_ctrl.sv
// Frame-synchronous convolution direction controller: mode changes only at a SOF
// reached after a full drain. Optional frame counter under IMG_CTRL_FRAME_CNT_EN.
//
// state    | meaning
// WAIT_SOF | idle between frames; next SOF latches the debounced mode
// ACTIVE   | frame in flight, mode frozen
// FLUSH    | pipeline draining after EOF for FLUSH_CYC cycles
module image_proc_ctrl
  import img_ctrl_pkg::*;
#(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int DEBOUNCE_CYC = 16,
  parameter int FLUSH_CYC    = 8
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iSW_MODE,
  input  logic               iDVAL,
  input  logic [COORD_W-1:0] iX_Cont,
  input  logic [COORD_W-1:0] iY_Cont,
  output logic               oMODE,
  output logic               oMODE_CHG,
  output logic               oBUSY
`ifdef IMG_CTRL_FRAME_CNT_EN
  ,
  output logic [15:0]        oFRAME_CNT
`endif
);

  localparam int FW = (FLUSH_CYC > 2) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FW-1:0]      FLUSH_LAST = FW'(FLUSH_CYC - 1);
  localparam logic [COORD_W-1:0] X_LAST     = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_LAST     = COORD_W'(V_ACTIVE - 1);

  ctrl_state_t   state, state_nxt;
  logic [FW-1:0] flush_cnt, flush_nxt;
  logic          mode_nxt;
  logic          chg_nxt;
  logic          sw_stable;
  logic          sof, eof;

  sw_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_deb (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iSW    (iSW_MODE),
    .oSTABLE(sw_stable)
  );

  assign sof = iDVAL && (iX_Cont == '0)    && (iY_Cont == '0);
  assign eof = iDVAL && (iX_Cont == X_LAST) && (iY_Cont == Y_LAST);

  always_comb begin
    state_nxt = state;
    flush_nxt = flush_cnt;
    mode_nxt  = oMODE;
    chg_nxt   = 1'b0;
    case (state)
      WAIT_SOF: begin
        if (sof) begin
          state_nxt = ACTIVE;
          mode_nxt  = (sw_stable == MODE_HORZ) ? MODE_HORZ : MODE_VERT;
          chg_nxt   = (mode_nxt != oMODE);
        end
      end
      ACTIVE: begin
        // EOF wins over SOF, so a truncated restart never skips the drain
        if (eof) begin
          state_nxt = FLUSH;
          flush_nxt = FLUSH_LAST;
        end
      end
      FLUSH: begin
        if (sof) begin
          state_nxt = ACTIVE;
        end else if (flush_cnt == '0) begin
          state_nxt = WAIT_SOF;
        end else begin
          flush_nxt = flush_cnt - FW'(1);
        end
      end
      default: state_nxt = WAIT_SOF;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= WAIT_SOF;
      flush_cnt <= '0;
      oMODE     <= MODE_VERT;
      oMODE_CHG <= 1'b0;
      oBUSY     <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_nxt;
      oMODE     <= mode_nxt;
      oMODE_CHG <= chg_nxt;
      oBUSY     <= (state_nxt != WAIT_SOF);
    end
  end

`ifdef IMG_CTRL_FRAME_CNT_EN
  logic frame_inc;
  assign frame_inc = (state == ACTIVE) && eof;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oFRAME_CNT <= '0;
    end else if (frame_inc) begin
      oFRAME_CNT <= oFRAME_CNT + 16'd1;
    end
  end
`endif

endmodule

// File: doc/image_proc_ctrl.md
Name: image_proc_ctrl

Overview:
Frame-synchronous mode controller for the greyscale→convolution image pipeline. It debounces the raw filter-select switch and drives the convolution direction select. The select changes only between frames, after the pipeline has drained, so a frame is never filtered with mixed kernels. It also reports pipeline busy state, mode-change events and a completed-frame count.

Parameters:
H_ACTIVE, 640, active pixels per line; EOF is detected at X = H_ACTIVE-1.
V_ACTIVE, 480, active lines per frame; EOF is detected at Y = V_ACTIVE-1.
DEBOUNCE_CYC, 16, cycles the synchronised switch must stay stable before it is accepted (minimum 2).
FLUSH_CYC, 8, drain cycles after EOF before a mode change may take effect (minimum 1).

Ports:
iCLK  input  1  clock
iRST  input  1  reset; synchronous, active-high
iSW_MODE  input  1  raw switch, asynchronous to iCLK; 0 = vertical, 1 = horizontal
iDVAL  input  1  pixel valid from the capture stage
iX_Cont  input  11  pixel column
iY_Cont  input  11  pixel row
oMODE  output  1  direction select to the convolution block
oMODE_CHG  output  1  one-cycle pulse when oMODE changes value
oBUSY  output  1  high while a frame is in flight or draining
oFRAME_CNT  output  16  completed frames, wraps (present only with the optional feature)

Behaviour:
- Clock and reset: one clock, iCLK. iRST is synchronous and active-high.
- Reset values:
  - all outputs 0
  - FSM = WAIT_SOF
  - debounced switch = 0
  - synchroniser flops = 0
  - debounce counter = 0
  - flush counter = 0
- Synchroniser: two-flop synchroniser on iSW_MODE produces sw_sync.
- Debounce:
  - If sw_sync equals the stable value, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYC-1, the stable value takes sw_sync and the counter clears.
  - Latency from a clean switch edge to the stable value updating is 2 + DEBOUNCE_CYC cycles.
  - A glitch shorter than DEBOUNCE_CYC cycles is ignored.
- Event decode (combinational):
  - SOF = iDVAL & X==0 & Y==0
  - EOF = iDVAL & X==H_ACTIVE-1 & Y==V_ACTIVE-1
- FSM states: WAIT_SOF, ACTIVE, FLUSH.
  - WAIT_SOF:
    - On SOF: next = ACTIVE. oMODE takes the stable value in the same edge, so the SOF pixel itself uses the old oMODE. Downstream tolerates this because the convolution window is not yet valid at the first pixel.
    - If the new oMODE differs from the old one, oMODE_CHG = 1 for one cycle.
  - ACTIVE:
    - On EOF: next = FLUSH, flush counter = FLUSH_CYC-1, frame count +1.
    - SOF while in ACTIVE (truncated frame): stay in ACTIVE, oMODE unchanged, frame count unchanged.
  - FLUSH:
    - The flush counter decrements each cycle. At 0, next = WAIT_SOF.
    - SOF while in FLUSH: next = ACTIVE, oMODE unchanged. The pending change is deferred to the next SOF reached from WAIT_SOF.
  - SOF and EOF in the same cycle (only possible when H_ACTIVE = V_ACTIVE = 1): EOF takes priority.
- oBUSY = (state != WAIT_SOF), registered; it reflects the current state.
- Switch changes while ACTIVE or FLUSH only update the stable value. The last stable value at the next qualifying SOF wins.
- iDVAL = 0 freezes event detection only. The debounce and flush counters keep running.
- Reset mid-frame: the state returns to WAIT_SOF and oMODE to 0. The following frame is treated as a fresh frame.

Optional Feature:
Macro: IMG_CTRL_FRAME_CNT_EN.
- Defined: oFRAME_CNT port and its 16-bit register exist. The count increments on each EOF taken in ACTIVE, wraps 0xFFFF→0, and resets to 0.
- Undefined: the port and register are omitted entirely.

Decomposition:
- Package img_ctrl_pkg:
  - state enum ctrl_state_t {WAIT_SOF, ACTIVE, FLUSH}, 2 bits
  - localparams MODE_VERT = 1'b0 and MODE_HORZ = 1'b1
  - coordinate width constant COORD_W = 11
- Sub-module sw_debounce (synchroniser plus stability counter, parameter DEBOUNCE_CYC). Its ports are iCLK, iRST, iSW, oSTABLE. It is reused for other board switches.

Test Plan:
- Reset, then a full 640x480 frame with iSW_MODE = 0:
  - oMODE stays 0 and oMODE_CHG never pulses.
  - oBUSY rises one cycle after SOF and falls FLUSH_CYC = 8 cycles after EOF.
  - oFRAME_CNT = 1.
- Set iSW_MODE = 1 mid-frame:
  - The stable value updates 18 cycles later.
  - oMODE stays 0 until the next SOF, then goes to 1 with a single oMODE_CHG pulse.
- Glitch iSW_MODE high for 10 cycles while idle → the stable value stays 0, and the next SOF produces no mode change.
- Start a new SOF 3 cycles after EOF (inside FLUSH) with the switch changed:
  - The state goes to ACTIVE and oMODE is unchanged.
  - The change is applied only at the SOF after a complete drain.
- Assert iRST while ACTIVE with oMODE = 1 → the next cycle shows oMODE = 0, oBUSY = 0 and oFRAME_CNT = 0.
- Preload the frame counter to 0xFFFF (force), run one frame → oFRAME_CNT wraps to 0x0000.
